led_mode_ctrl: RTL
==================

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter LED_NUM, default 8: LED count, legal 2..32.
REQ-002 SHALL have parameter TICK_DIV, default 1000: clk cycles per pattern tick, legal >= 2.
REQ-003 SHALL have parameter DEB_TICKS, default 4: ticks a new switch value must stay stable before acceptance, legal >= 1.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_sw  input  2  asynchronous mode switch: 0 off, 1 blink, 2 shift, 3 bounce.
REQ-007 SHALL have port o_led  output  LED_NUM  registered LED pattern.
REQ-008 SHALL have port o_mode  output  2  currently accepted (debounced) mode, registered.
REQ-009 SHALL have port o_tick  output  1  one-cycle pulse marking each pattern tick.

Function
REQ-010 SHALL run a prescaler div_cnt counting 0..TICK_DIV-1 and wrapping to 0.
REQ-011 SHALL drive o_tick high exactly while div_cnt == TICK_DIV-1; first pulse is on cycle TICK_DIV-1 after reset release, then every TICK_DIV cycles.
REQ-012 SHALL pass i_sw through a 2-flop synchroniser (sw_s) before any use.
REQ-013 SHALL keep a candidate register cand and a debounce counter deb_cnt; when sw_s != cand: cand <= sw_s, deb_cnt <= 0, regardless of tick.
REQ-014 SHALL, on a tick with sw_s == cand and cand != o_mode, load o_mode <= cand and clear deb_cnt if deb_cnt == DEB_TICKS-1, else increment deb_cnt.
REQ-015 SHALL hold deb_cnt at 0 while cand == o_mode; a glitch that returns to the accepted mode before acceptance leaves o_mode unchanged.
REQ-016 SHALL, in the cycle o_mode is loaded, reinitialise o_led: off 0; blink all ones; shift 1 (bit 0); bounce 1 with direction up.
REQ-017 SHALL, on a tick with no mode load in that cycle, step o_led per o_mode: off stays 0; blink inverts every bit; shift rotates left with bit LED_NUM-1 wrapping to bit 0.
REQ-018 SHALL, in bounce mode, move the single set bit one position per tick toward MSB while direction up and toward LSB while down; reverse direction in the cycle the set bit reaches bit LED_NUM-1 or bit 0, so no end position repeats (LED_NUM=4: 0001,0010,0100,1000,0100,0010,0001,0010...).
REQ-019 SHALL give mode load priority over a pattern step in the same cycle (the reinitialised value is output; no step applied).
REQ-020 SHALL hold o_led unchanged on non-tick cycles without a mode load.
REQ-021 SHALL keep every counter within its declared width; no overflow at max parameter values.

Reset
REQ-022 SHALL, in any cycle rst is high, set o_led=0, o_mode=0, div_cnt=0, deb_cnt=0, cand=0, sw_s flops=0, direction=up; o_tick is therefore 0.
REQ-023 SHALL let rst asserted mid-pattern or mid-debounce abort immediately; after release operation restarts as from power-up with mode 0.

Verification (LED_NUM=4, TICK_DIV=4, DEB_TICKS=2 unless stated)
REQ-024 SHALL cover: rst high 5 cycles, i_sw=0 -> o_led=0, o_mode=0; o_tick first high on cycle 3 after release, then every 4 cycles.
REQ-025 SHALL cover: i_sw 0->2 held -> o_mode=2 and o_led=0001 on the 2nd tick after cand captures 2; subsequent ticks give 0010,0100,1000,0001.
REQ-026 SHALL cover: mode 3 held 8 ticks -> o_led 0001,0010,0100,1000,0100,0010,0001,0010,0100.
REQ-027 SHALL cover: in mode 1, i_sw pulses to 3 for 1 tick then returns to 1 -> o_mode stays 1, blink continues 1111/0000 each tick without restart.
REQ-028 SHALL cover: rst asserted 1 cycle while mode 2 with o_led=0100 -> next cycle o_led=0, o_mode=0; with i_sw still 2, mode 2 reaccepted and o_led=0001 per REQ-025 timing.
REQ-029 SHALL cover: LED_NUM=2, TICK_DIV=2, DEB_TICKS=1, mode 3 -> o_led alternates 01,10 every tick; mode 1 -> alternates 11,00.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// LED pattern controller: a debounced 2-bit mode switch selects off, blink,
// shift or bounce patterns, stepped once per prescaler tick.
module led_mode_ctrl #(
    parameter int LED_NUM   = 8,
    parameter int TICK_DIV  = 1000,
    parameter int DEB_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         i_sw,
    output logic [LED_NUM-1:0] o_led,
    output logic [1:0]         o_mode,
    output logic               o_tick
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DEB_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_TICKS - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_SHIFT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    logic [DIV_W-1:0]   div_cnt_reg;
    logic [1:0]         sw_meta_reg;
    logic [1:0]         sw_s_reg;
    logic [1:0]         cand_reg;
    logic [DEB_W-1:0]   deb_cnt_reg, deb_cnt_next;
    mode_t              mode_reg, mode_next;
    logic [LED_NUM-1:0] led_reg, led_next;
    logic               dir_up_reg, dir_up_next;
    logic               tick;
    logic               load;
    logic [LED_NUM-1:0] bounce_step;

    assign tick        = (div_cnt_reg == DIV_MAX);
    assign bounce_step = dir_up_reg ? (led_reg << 1) : (led_reg >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            sw_meta_reg <= '0;
            sw_s_reg    <= '0;
            cand_reg    <= '0;
            deb_cnt_reg <= '0;
            mode_reg    <= MODE_OFF;
            led_reg     <= '0;
            dir_up_reg  <= 1'b1;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
            sw_meta_reg <= i_sw;
            sw_s_reg    <= sw_meta_reg;
            cand_reg    <= sw_s_reg;
            deb_cnt_reg <= deb_cnt_next;
            mode_reg    <= mode_next;
            led_reg     <= led_next;
            dir_up_reg  <= dir_up_next;
        end
    end

    always_comb begin
        deb_cnt_next = deb_cnt_reg;
        mode_next    = mode_reg;
        led_next     = led_reg;
        dir_up_next  = dir_up_reg;
        load         = 1'b0;

        // A changing candidate restarts the stability window; an already
        // accepted candidate keeps the counter parked at zero.
        if (sw_s_reg != cand_reg) begin
            deb_cnt_next = '0;
        end else if (cand_reg == mode_reg) begin
            deb_cnt_next = '0;
        end else if (tick) begin
            if (deb_cnt_reg == DEB_MAX) begin
                load         = 1'b1;
                mode_next    = mode_t'(cand_reg);
                deb_cnt_next = '0;
            end else begin
                deb_cnt_next = deb_cnt_reg + DEB_W'(1);
            end
        end

        if (load) begin
            dir_up_next = 1'b1;
            case (mode_next)
                MODE_OFF:   led_next = '0;
                MODE_BLINK: led_next = '1;
                default:    led_next = LED_NUM'(1);
            endcase
        end else if (tick) begin
            case (mode_reg)
                MODE_OFF:   led_next = '0;
                MODE_BLINK: led_next = ~led_reg;
                MODE_SHIFT: led_next = {led_reg[LED_NUM-2:0], led_reg[LED_NUM-1]};
                default: begin
                    // Flip direction as soon as an end is reached so the
                    // end position is shown for exactly one tick.
                    led_next = bounce_step;
                    if (bounce_step[LED_NUM-1])
                        dir_up_next = 1'b0;
                    else if (bounce_step[0])
                        dir_up_next = 1'b1;
                end
            endcase
        end
    end

    assign o_led  = led_reg;
    assign o_mode = mode_reg;
    assign o_tick = tick;

endmodule
